uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
- Round-robin scheduler that shares the single 16x-oversampled UART transmitter among 4 byte-producing requesters (loop-back control, status reporter, debug dump, spare).
- Sits between the requesters and the transmitter's datain/wrsig/busy interface, in the 16x baud clock domain.
- Sequences one frame at a time and enforces an inter-frame guard gap.

Parameters:
- GUARD_CYCLES, 16: idle clk cycles inserted after tx_busy falls before the next grant (1..255).
- BUSY_TIMEOUT, 64: clk cycles allowed after the wrsig pulse for tx_busy to rise before the frame is abandoned (2..255).

Ports:
- clk  input  1  16x baud clock, shared with the transmitter.
- reset  input  1  asynchronous, active-low reset.
- req  input  4  per-requester request; held high with data stable until ack.
- req_data  input  32  packed bytes; requester i uses bits [8i+7:8i].
- ack  output  4  one-hot, one-cycle pulse when requester i's byte is latched.
- txdata  output  8  byte to transmitter datain; registered.
- wrsig  output  1  one-cycle start pulse to transmitter.
- tx_busy  input  1  transmitter busy; high while a frame is shifting out.
- timeout_err  output  1  sticky; set when BUSY_TIMEOUT expires; cleared only by reset.
- cur_grant  output  2  index of the last granted requester.

Behaviour:
- Reset (async, reset=0) values:
  - state=IDLE; ack=0; txdata=8'h00; wrsig=0; timeout_err=0; cur_grant=2'd3.
  - Round-robin pointer=3, so requester 0 wins the first arbitration.
- IDLE:
  - If req!=0 and tx_busy=0, pick the winner by searching upward from (pointer+1) mod 4.
  - Next edge: txdata<=req_data[winner], ack<=onehot(winner), wrsig<=1, pointer/cur_grant<=winner; go to LOAD.
  - If tx_busy=1 while in IDLE (foreign traffic), wait; no grant.
- LOAD (1 cycle): ack and wrsig are high during this cycle only; they clear on exit. Go to WAIT_BUSY with timer=0.
- Request-to-wrsig latency: exactly 1 clk.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise timer increments; when timer reaches BUSY_TIMEOUT-1, set timeout_err and go to GAP.
- WAIT_DONE: when tx_busy=0, go to GAP with gap counter=0.
- GAP: counter increments each cycle. At GUARD_CYCLES-1, go to IDLE. Arbitration is next possible on the following cycle.
- Requests arriving in any non-IDLE state are held pending; they are never lost or acked early.
- Round-robin fairness: with all 4 requesting continuously, the grant order is 0,1,2,3,0,...
- A requester that drops req before ack is simply not considered; no ack is issued to it.
- req_data is sampled only on the IDLE->LOAD edge. txdata holds its value until the next grant.
- Simultaneous tx_busy rise and timer expiry in the same cycle: tx_busy wins, go to WAIT_DONE, no error.
- Reset asserted mid-frame: all outputs return to reset values immediately. The pending frame is not re-sent.
- Counters are 8 bits wide and saturate (they never wrap) given the parameter ranges.

Optional Feature:
- Macro: UART_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. Whenever req[0]=1 in IDLE, it wins regardless of the pointer; requesters 1-3 keep round-robin among themselves, and the pointer is not updated by grants to 0.
- Undefined: pure 4-way round-robin as above.

Test Plan:
- Single request: req=4'b0100, req_data[23:16]=8'hA5, tx_busy model rises 2 cycles after wrsig and lasts 160 cycles → ack=4'b0100 and wrsig together, 1 clk after req; txdata=8'hA5; next grant no earlier than 16 cycles after tx_busy falls.
- All requesting: req=4'b1111 held through 8 frames, bytes 8'h10/8'h21/8'h32/8'h43 → ack order 0,1,2,3,0,1,2,3; transmitted bytes 10,21,32,43,10,21,32,43.
- Timeout: tx_busy held 0 after wrsig → timeout_err=1 exactly 64 cycles after wrsig; arbiter returns to IDLE after 16 further gap cycles and serves the next req.
- Busy edge at the timeout cycle: tx_busy rises on cycle 63 after wrsig → no timeout_err; state WAIT_DONE.
- Reset mid-frame: reset=0 while in WAIT_DONE → ack=0, wrsig=0, txdata=00, cur_grant=3, timeout_err=0; after release, req=4'b0001 is granted first.
- With UART_ARB_PRIO0_EN: req=4'b1111 continuous → ack order 0,0,0,...; with req[0] toggled off every other frame → order 0,1,0,2,0,3.

Source files
------------

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin scheduler sharing one 16x-oversampled UART
// transmitter among four byte-producing requesters. It issues one frame at a
// time, waits for the transmitter to go busy and idle again, then holds off
// for a guard gap before the next grant.
// Optional build macro: UART_ARB_PRIO0_EN gives requester 0 strict priority
// over the round-robin among requesters 1-3.
module uart_tx_arb #(
    parameter int unsigned GUARD_CYCLES = 16,  // 1..255
    parameter int unsigned BUSY_TIMEOUT = 64   // 2..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  ack,
    output logic [7:0]  txdata,
    output logic        wrsig,
    input  logic        tx_busy,
    output logic        timeout_err,
    output logic [1:0]  cur_grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(BUSY_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GUARD_CYCLES - 1);

    state_t      state_q;
    logic [1:0]  ptr_q;
    logic [7:0]  timer_q;
    logic [7:0]  gap_q;
    logic [3:0]  ack_q;
    logic [7:0]  txdata_q;
    logic        wrsig_q;
    logic        timeout_err_q;
    logic [1:0]  cur_grant_q;

    logic [3:0]  rr_req;
    logic [1:0]  cand;
    logic        win_valid;
    logic [1:0]  win_idx;

    // Pick the winner: search upward from the slot after the last round-robin grant.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        rr_req    = req;
        cand      = 2'd0;
        win_valid = 1'b0;
        win_idx   = ptr_q;
`ifdef UART_ARB_PRIO0_EN
        rr_req[0] = 1'b0;
`endif
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!win_valid && rr_req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
`ifdef UART_ARB_PRIO0_EN
        if (req[0]) begin
            win_valid = 1'b1;
            win_idx   = 2'd0;
        end
`endif
    end

    // Frame sequencer with registered outputs: grant, wait for busy, wait for idle, guard gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= 2'd3;
            timer_q       <= 8'd0;
            gap_q         <= 8'd0;
            ack_q         <= 4'd0;
            txdata_q      <= 8'h00;
            wrsig_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            cur_grant_q   <= 2'd3;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values.
            ack_q   <= 4'd0;
            wrsig_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    // Foreign traffic on the transmitter blocks arbitration.
                    if (win_valid && !tx_busy) begin
                        txdata_q    <= req_data[8*win_idx +: 8];
                        ack_q       <= 4'b0001 << win_idx;
                        wrsig_q     <= 1'b1;
                        cur_grant_q <= win_idx;
`ifdef UART_ARB_PRIO0_EN
                        // Priority grants to requester 0 leave the round-robin position alone.
                        if (win_idx != 2'd0) begin
                            ptr_q <= win_idx;
                        end
`else
                        ptr_q <= win_idx;
`endif
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    timer_q <= 8'd0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // Busy rising on the expiry cycle takes precedence over the timeout.
                    if (tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (timer_q == TIMER_LAST - 8'd1) begin
                        timer_q       <= TIMER_LAST;
                        timeout_err_q <= 1'b1;
                        gap_q         <= 8'd0;
                        state_q       <= S_GAP;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        gap_q   <= 8'd0;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_q;
    assign txdata      = txdata_q;
    assign wrsig       = wrsig_q;
    assign timeout_err = timeout_err_q;
    assign cur_grant   = cur_grant_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed bench for uart_tx_arb. A table of single-frame
// grants covers round-robin order and data selection; hand-written sequences
// cover guard gap, busy timeout, busy/timeout tie and mid-frame reset.
// Build with UART_ARB_PRIO0_EN defined to exercise the priority variant.
module tb_uart_tx_arb;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  txdata;
    logic        wrsig;
    logic        tx_busy;
    logic        timeout_err;
    logic [1:0]  cur_grant;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_arb #(
        .GUARD_CYCLES(16),
        .BUSY_TIMEOUT(64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .txdata     (txdata),
        .wrsig      (wrsig),
        .tx_busy    (tx_busy),
        .timeout_err(timeout_err),
        .cur_grant  (cur_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_byte;
        logic [1:0]  exp_grant;
    } vec_t;

    function automatic vec_t mk(logic [3:0] r, logic [31:0] d, logic [3:0] a,
                                logic [7:0] b, logic [1:0] g);
        vec_t v;
        v.req       = r;
        v.data      = d;
        v.exp_ack   = a;
        v.exp_byte  = b;
        v.exp_grant = g;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns the number of rising edges until wrsig is seen high (sampled 1 time unit after the edge).
    task automatic wait_wrsig(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (wrsig) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wrsig_wait: no wrsig within %0d cycles", limit);
        end
    endtask

    task automatic do_reset();
        req      = 4'd0;
        req_data = 32'd0;
        tx_busy  = 1'b0;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Transmitter model: busy rises 2 cycles after wrsig and lasts len cycles.
    task automatic tx_frame(input int len);
        @(posedge clk);
        #1;
        tx_busy = 1'b1;
        repeat (len) @(posedge clk);
        #1;
        tx_busy = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   lat;
        logic quiet;

`ifdef UART_ARB_PRIO0_EN
        vecs.push_back(mk(4'b1111, 32'h4332_2110, 4'b0001, 8'h10, 2'd0));
        vecs.push_back(mk(4'b1111, 32'h4332_2110, 4'b0001, 8'h10, 2'd0));
        vecs.push_back(mk(4'b1111, 32'h4332_2110, 4'b0001, 8'h10, 2'd0));
        vecs.push_back(mk(4'b1111, 32'h4332_2110, 4'b0001, 8'h10, 2'd0));
        vecs.push_back(mk(4'b1110, 32'h4332_2110, 4'b0010, 8'h21, 2'd1));
        vecs.push_back(mk(4'b1111, 32'h4332_2110, 4'b0001, 8'h10, 2'd0));
        vecs.push_back(mk(4'b1110, 32'h4332_2110, 4'b0100, 8'h32, 2'd2));
        vecs.push_back(mk(4'b1111, 32'h4332_2110, 4'b0001, 8'h10, 2'd0));
        vecs.push_back(mk(4'b1110, 32'h4332_2110, 4'b1000, 8'h43, 2'd3));
        vecs.push_back(mk(4'b1010, 32'hDDCC_BBAA, 4'b0010, 8'hBB, 2'd1));
        vecs.push_back(mk(4'b1011, 32'hDDCC_BBAA, 4'b0001, 8'hAA, 2'd0));
        vecs.push_back(mk(4'b1010, 32'hDDCC_BBAA, 4'b1000, 8'hDD, 2'd3));
`else
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(4'b1111, 32'h4332_2110, 4'b0001, 8'h10, 2'd0));
            vecs.push_back(mk(4'b1111, 32'h4332_2110, 4'b0010, 8'h21, 2'd1));
            vecs.push_back(mk(4'b1111, 32'h4332_2110, 4'b0100, 8'h32, 2'd2));
            vecs.push_back(mk(4'b1111, 32'h4332_2110, 4'b1000, 8'h43, 2'd3));
        end
        vecs.push_back(mk(4'b1010, 32'hDDCC_BBAA, 4'b0010, 8'hBB, 2'd1));
        vecs.push_back(mk(4'b1010, 32'hDDCC_BBAA, 4'b1000, 8'hDD, 2'd3));
        vecs.push_back(mk(4'b0110, 32'hDDCC_BBAA, 4'b0010, 8'hBB, 2'd1));
        vecs.push_back(mk(4'b0110, 32'hDDCC_BBAA, 4'b0100, 8'hCC, 2'd2));
        vecs.push_back(mk(4'b0001, 32'hDDCC_BBAA, 4'b0001, 8'hAA, 2'd0));
        vecs.push_back(mk(4'b1001, 32'hDDCC_BBAA, 4'b1000, 8'hDD, 2'd3));
`endif

        // ---------------- reset values ----------------
        do_reset();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_wrsig", 32'(wrsig), 32'h0);
        check("rst_txdata", 32'(txdata), 32'h00);
        check("rst_grant", 32'(cur_grant), 32'd3);
        check("rst_timeout", 32'(timeout_err), 32'h0);

        // ---------------- table: round-robin order and byte selection ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            req      = vecs[i].req;
            req_data = vecs[i].data;
            wait_wrsig(64, lat);
            check($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
            check($sformatf("vec%0d_txdata", i), 32'(txdata), 32'(vecs[i].exp_byte));
            check($sformatf("vec%0d_grant", i), 32'(cur_grant), 32'(vecs[i].exp_grant));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pulse", i), {27'd0, ack, wrsig}, 32'h0);
            tx_frame(8);
            check($sformatf("vec%0d_hold", i), 32'(txdata), 32'(vecs[i].exp_byte));
        end

        // ---------------- single request, pending request, guard gap ----------------
        do_reset();
        req      = 4'b0100;
        req_data = 32'h00A5_0000;
        wait_wrsig(64, lat);
        check("single_latency", 32'(lat), 32'd1);
        check("single_ack", 32'(ack), 32'b0100);
        check("single_txdata", 32'(txdata), 32'hA5);
        check("single_grant", 32'(cur_grant), 32'd2);
        req = 4'b0000;
        @(posedge clk);
        #1;
        check("single_pulse", {27'd0, ack, wrsig}, 32'h0);
        @(posedge clk);
        #1;
        tx_busy  = 1'b1;
        req      = 4'b0001;
        req_data = 32'h00A5_005A;
        quiet    = 1'b1;
        repeat (160) begin
            @(posedge clk);
            #1;
            if (ack != 4'd0 || wrsig) quiet = 1'b0;
        end
        tx_busy = 1'b0;
        check("pending_held", 32'(quiet), 32'd1);
        // One edge to see busy low, 16 guard cycles, then the IDLE arbitration edge.
        wait_wrsig(64, lat);
        check("guard_gap", 32'(lat), 32'd18);
        check("pending_ack", 32'(ack), 32'b0001);
        check("pending_txdata", 32'(txdata), 32'h5A);
        check("pending_grant", 32'(cur_grant), 32'd0);
        req = 4'b0000;

        // ---------------- busy timeout ----------------
        do_reset();
        req      = 4'b0010;
        req_data = 32'h0000_7700;
        wait_wrsig(64, lat);
        check("to_ack", 32'(ack), 32'b0010);
        req = 4'b0000;
        repeat (63) @(posedge clk);
        #1;
        check("to_not_yet", 32'(timeout_err), 32'd0);
        @(posedge clk);
        #1;
        check("to_set_at_64", 32'(timeout_err), 32'd1);
        req      = 4'b1000;
        req_data = 32'h8800_0000;
        // Timeout edge enters the gap; 16 gap cycles, then one IDLE edge to grant.
        wait_wrsig(64, lat);
        check("to_regrant_lat", 32'(lat), 32'd17);
        check("to_regrant_ack", 32'(ack), 32'b1000);
        check("to_regrant_txdata", 32'(txdata), 32'h88);
        check("to_regrant_grant", 32'(cur_grant), 32'd3);
        req = 4'b0000;
        tx_frame(4);
        check("to_sticky", 32'(timeout_err), 32'd1);

        // ---------------- busy rises on the timeout cycle ----------------
        do_reset();
        req      = 4'b0100;
        req_data = 32'h003C_0000;
        wait_wrsig(64, lat);
        req = 4'b0000;
        repeat (63) @(posedge clk);
        #1;
        tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("tie_no_error", 32'(timeout_err), 32'd0);
        tx_busy  = 1'b0;
        req      = 4'b0001;
        req_data = 32'h0000_00C3;
        // Having waited in WAIT_DONE, the next grant follows the full guard gap.
        wait_wrsig(64, lat);
        check("tie_regrant_lat", 32'(lat), 32'd18);
        check("tie_regrant_ack", 32'(ack), 32'b0001);
        check("tie_still_no_error", 32'(timeout_err), 32'd0);
        req = 4'b0000;

        // ---------------- reset mid-frame ----------------
        do_reset();
        req      = 4'b0100;
        req_data = 32'h00E1_0000;
        wait_wrsig(64, lat);
        req = 4'b0000;
        @(posedge clk);
        #1;
        tx_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_txdata_before", 32'(txdata), 32'hE1);
        reset = 1'b0;
        #2;
        check("mid_ack", 32'(ack), 32'h0);
        check("mid_wrsig", 32'(wrsig), 32'h0);
        check("mid_txdata", 32'(txdata), 32'h00);
        check("mid_grant", 32'(cur_grant), 32'd3);
        check("mid_timeout", 32'(timeout_err), 32'h0);
        tx_busy = 1'b0;
        reset   = 1'b1;
        quiet   = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (wrsig || ack != 4'd0) quiet = 1'b0;
        end
        check("mid_no_resend", 32'(quiet), 32'd1);
        req      = 4'b0011;
        req_data = 32'h0000_F00F;
        wait_wrsig(64, lat);
        check("mid_first_lat", 32'(lat), 32'd1);
        check("mid_first_ack", 32'(ack), 32'b0001);
        check("mid_first_txdata", 32'(txdata), 32'h0F);
        check("mid_first_grant", 32'(cur_grant), 32'd0);
        req = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
